// File: rtl/traffic_light_ctrl.sv
// Two-direction traffic-light phase controller with per-direction seconds countdown.
// Define TRAFFIC_ALL_RED_EN to insert all-red clearance phases between direction changes.
module traffic_light_ctrl #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int GREEN_TIME   = 30,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic [7:0] cnt_ns,
  output logic [7:0] cnt_ew
);

`ifdef TRAFFIC_ALL_RED_EN
  localparam bit ALL_RED_EN = 1'b1;
`else
  localparam bit ALL_RED_EN = 1'b0;
`endif

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  localparam logic [7:0] G  = 8'(GREEN_TIME);
  localparam logic [7:0] Y  = 8'(YELLOW_TIME);
  // Clearance adds nothing to the red-side sums when the all-red phases are absent.
  localparam logic [7:0] AR = ALL_RED_EN ? 8'(ALL_RED_TIME) : 8'd0;
  localparam logic [7:0] RST_CNT_EW = G + Y + AR;

  localparam logic [2:0] NS_GREEN  = 3'd0;
  localparam logic [2:0] NS_YELLOW = 3'd1;
  localparam logic [2:0] EW_GREEN  = 3'd3;
  localparam logic [2:0] EW_YELLOW = 3'd4;
`ifdef TRAFFIC_ALL_RED_EN
  localparam logic [2:0] ALL_RED_A = 3'd2;
  localparam logic [2:0] ALL_RED_B = 3'd5;
`endif

  logic [PW-1:0] prescaler;
  logic [2:0]    phase;
  logic [7:0]    remain;
  logic          tick;

  logic [2:0] succ;
  logic [7:0] succ_dur;
  logic       legal;
  logic [2:0] nxt_phase;
  logic [7:0] nxt_remain;

  logic [2:0] d_light_ns, d_light_ew;
  logic [7:0] d_cnt_ns, d_cnt_ew;

  assign tick = (prescaler == PRE_MAX) && !pause;

  always_comb begin
    legal    = 1'b1;
    succ     = NS_GREEN;
    succ_dur = G;
    case (phase)
      NS_GREEN:  begin succ = NS_YELLOW; succ_dur = Y; end
`ifdef TRAFFIC_ALL_RED_EN
      NS_YELLOW: begin succ = ALL_RED_A; succ_dur = AR; end
      ALL_RED_A: begin succ = EW_GREEN;  succ_dur = G;  end
      EW_GREEN:  begin succ = EW_YELLOW; succ_dur = Y;  end
      EW_YELLOW: begin succ = ALL_RED_B; succ_dur = AR; end
      ALL_RED_B: begin succ = NS_GREEN;  succ_dur = G;  end
`else
      NS_YELLOW: begin succ = EW_GREEN;  succ_dur = G; end
      EW_GREEN:  begin succ = EW_YELLOW; succ_dur = Y; end
      EW_YELLOW: begin succ = NS_GREEN;  succ_dur = G; end
`endif
      default:   legal = 1'b0;
    endcase
  end

  always_comb begin
    nxt_phase  = phase;
    nxt_remain = remain;
    if (!legal) begin
      nxt_phase  = NS_GREEN;
      nxt_remain = G;
    end else if (tick) begin
      if (remain > 8'd1) begin
        nxt_remain = remain - 8'd1;
      end else begin
        nxt_phase  = succ;
        nxt_remain = succ_dur;
      end
    end
  end

  // Outputs are decoded from the post-edge state so they carry no extra lag.
  always_comb begin
    d_light_ns = 3'b100;
    d_light_ew = 3'b100;
    d_cnt_ns   = nxt_remain;
    d_cnt_ew   = nxt_remain;
    case (nxt_phase)
      NS_GREEN:  begin d_light_ns = 3'b001; d_cnt_ew = nxt_remain + Y + AR; end
      NS_YELLOW: begin d_light_ns = 3'b010; d_cnt_ew = nxt_remain + AR;     end
      EW_GREEN:  begin d_light_ew = 3'b001; d_cnt_ns = nxt_remain + Y + AR; end
      EW_YELLOW: begin d_light_ew = 3'b010; d_cnt_ns = nxt_remain + AR;     end
`ifdef TRAFFIC_ALL_RED_EN
      ALL_RED_A: d_cnt_ns = nxt_remain + G + Y + AR;
      ALL_RED_B: d_cnt_ew = nxt_remain + G + Y + AR;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      phase     <= NS_GREEN;
      remain    <= G;
      light_ns  <= 3'b001;
      light_ew  <= 3'b100;
      cnt_ns    <= G;
      cnt_ew    <= RST_CNT_EW;
    end else begin
      if (!pause) prescaler <= (prescaler == PRE_MAX) ? '0 : prescaler + 1'b1;
      phase    <= nxt_phase;
      remain   <= nxt_remain;
      light_ns <= d_light_ns;
      light_ew <= d_light_ew;
      cnt_ns   <= d_cnt_ns;
      cnt_ew   <= d_cnt_ew;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboarded bench: a phase-table model predicts every cycle, a monitor compares the DUTs.
module tb_traffic_light_ctrl;

`ifdef TRAFFIC_ALL_RED_EN
  localparam int NPH = 6;
  localparam int BG = 88, BY = 7, BA = 2;
`else
  localparam int NPH = 4;
  localparam int BG = 90, BY = 9, BA = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pause = 1'b0;
  logic [2:0] lns0, lew0, lns1, lew1;
  logic [7:0] cns0, cew0, cns1, cew1;

  always #5 clk = ~clk;

  traffic_light_ctrl #(.TICK_DIV(4), .GREEN_TIME(5), .YELLOW_TIME(2), .ALL_RED_TIME(1)) dut0 (
    .clk(clk), .rst(rst), .pause(pause),
    .light_ns(lns0), .light_ew(lew0), .cnt_ns(cns0), .cnt_ew(cew0));

  traffic_light_ctrl #(.TICK_DIV(2), .GREEN_TIME(BG), .YELLOW_TIME(BY), .ALL_RED_TIME(BA)) dut1 (
    .clk(clk), .rst(rst), .pause(pause),
    .light_ns(lns1), .light_ew(lew1), .cnt_ns(cns1), .cnt_ew(cew1));

  typedef struct packed {
    logic [2:0] lns;
    logic [2:0] lew;
    logic [7:0] cns;
    logic [7:0] cew;
  } obs_t;

  obs_t exp_q0[$];
  obs_t exp_q1[$];
  int total = 0;
  int bad = 0;

  // Reference model: phase index into a table, seconds left, unpaused cycles in this second.
  int ph[2], rem[2], elapsed[2], td[2];
  int dur[2][NPH];
  logic [2:0] lt_ns[NPH];
  logic [2:0] lt_ew[NPH];

  function automatic obs_t view(int i);
    obs_t o;
    int sn, se, k;
    sn = rem[i];
    se = rem[i];
    // A countdown runs until that direction's lamp differs from what it shows now.
    k = (ph[i] + 1) % NPH;
    while (lt_ns[k] == lt_ns[ph[i]]) begin sn += dur[i][k]; k = (k + 1) % NPH; end
    k = (ph[i] + 1) % NPH;
    while (lt_ew[k] == lt_ew[ph[i]]) begin se += dur[i][k]; k = (k + 1) % NPH; end
    o.lns = lt_ns[ph[i]];
    o.lew = lt_ew[ph[i]];
    o.cns = 8'(sn);
    o.cew = 8'(se);
    return o;
  endfunction

  task automatic step_model(int i, bit r, bit p);
    if (r) begin
      ph[i] = 0; rem[i] = dur[i][0]; elapsed[i] = 0;
    end else if (!p) begin
      elapsed[i]++;
      if (elapsed[i] == td[i]) begin
        elapsed[i] = 0;
        if (rem[i] > 1) rem[i]--;
        else begin
          ph[i] = (ph[i] + 1) % NPH;
          rem[i] = dur[i][ph[i]];
        end
      end
    end
  endtask

  task automatic drive(bit r, bit p);
    @(negedge clk);
    rst = r;
    pause = p;
    step_model(0, r, p);
    step_model(1, r, p);
    exp_q0.push_back(view(0));
    exp_q1.push_back(view(1));
  endtask

  task automatic run(int n, bit p);
    for (int c = 0; c < n; c++) drive(1'b0, p);
  endtask

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cmp(string tag, obs_t a, obs_t e);
    chk({tag, ".light_ns"}, int'(a.lns), int'(e.lns));
    chk({tag, ".light_ew"}, int'(a.lew), int'(e.lew));
    chk({tag, ".cnt_ns"},   int'(a.cns), int'(e.cns));
    chk({tag, ".cnt_ew"},   int'(a.cew), int'(e.cew));
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        cmp("dut0", {lns0, lew0, cns0, cew0}, e);
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        cmp("dut1", {lns1, lew1, cns1, cew1}, e);
        chk("dut1.cnt_ns_le_99", int'(cns1 <= 8'd99), 1);
        chk("dut1.cnt_ew_le_99", int'(cew1 <= 8'd99), 1);
      end
    end
  end

  initial begin : stimulus
    td[0] = 4;
    td[1] = 2;
`ifdef TRAFFIC_ALL_RED_EN
    lt_ns = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    lt_ew = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    dur[0] = '{5, 2, 1, 5, 2, 1};
    dur[1] = '{BG, BY, BA, BG, BY, BA};
`else
    lt_ns = '{3'b001, 3'b010, 3'b100, 3'b100};
    lt_ew = '{3'b100, 3'b100, 3'b001, 3'b010};
    dur[0] = '{5, 2, 5, 2};
    dur[1] = '{BG, BY, BG, BY};
`endif
    for (int i = 0; i < 2; i++) begin ph[i] = 0; rem[i] = dur[i][0]; elapsed[i] = 0; end

    // Reset, then a little more than one full cycle unpaused.
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    run(64, 1'b0);
    // Pause for 10 cycles with cnt_ns=4 and two unpaused cycles left in that second.
    drive(1'b1, 1'b0);
    run(6, 1'b0);
    run(10, 1'b1);
    run(20, 1'b0);
    // Reset during EW_YELLOW one cycle before a tick.
    drive(1'b1, 1'b0);
    run(55, 1'b0);
    drive(1'b1, 1'b0);
    run(12, 1'b0);
    // Long random pause/reset mix; the big-number instance sweeps several full cycles.
    for (int c = 0; c < 3000; c++)
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0);
    @(negedge clk);
    @(negedge clk);
    chk("queue0_drained", exp_q0.size(), 0);
    chk("queue1_drained", exp_q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
